// File: rtl/ps2_key_sequencer.sv
// PS/2 scan-code sequencer: pops bytes from the receiver FIFO, folds E0/F0 prefixes
// into key events, and tracks the held key, press count and sticky error flags.
module ps2_key_sequencer #(
  parameter logic [23:0] PREFIX_TIMEOUT = 24'd1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] fifo_data,
  input  logic       fifo_ready,
  input  logic       fifo_overflow,
  output logic       fifo_nextdata_n,
  input  logic       clr_err,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_release,
  output logic       key_repeat,
  output logic       key_held,
  output logic [7:0] press_count,
  output logic       overflow_err,
  output logic       timeout_err
);

  localparam logic [1:0] WAIT = 2'd0;
  localparam logic [1:0] POP  = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  logic [1:0]  state;
  logic        ext_pend;
  logic        brk_pend;
  logic [23:0] timer;
  logic [23:0] timer_inc;
  logic [7:0]  held_code;
  logic        held_ext;
  logic        held_match;
  logic        timer_expired;

  assign timer_inc  = timer + 24'd1;
  assign held_match = key_held && (held_code == fifo_data) && (held_ext == ext_pend);

  // A prefix only ages while the FSM is idle with nothing new to pop.
  assign timer_expired = (state == WAIT) && !fifo_ready && (ext_pend || brk_pend) &&
                         (timer_inc >= PREFIX_TIMEOUT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= WAIT;
      fifo_nextdata_n <= 1'b1;
      key_valid       <= 1'b0;
      key_code        <= 8'h00;
      key_ext         <= 1'b0;
      key_release     <= 1'b0;
      key_repeat      <= 1'b0;
      key_held        <= 1'b0;
      press_count     <= 8'h00;
      ext_pend        <= 1'b0;
      brk_pend        <= 1'b0;
      timer           <= 24'd0;
      held_code       <= 8'h00;
      held_ext        <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        WAIT: begin
          if (fifo_ready) begin
            // The byte is classified as it is latched so key_valid lines up with the pop cycle.
            state           <= POP;
            fifo_nextdata_n <= 1'b0;
            timer           <= 24'd0;
            if (fifo_data == CODE_EXT) begin
              ext_pend <= 1'b1;
            end else if (fifo_data == CODE_BRK) begin
              brk_pend <= 1'b1;
            end else begin
              key_valid   <= 1'b1;
              key_code    <= fifo_data;
              key_ext     <= ext_pend;
              key_release <= brk_pend;
              ext_pend    <= 1'b0;
              brk_pend    <= 1'b0;
              if (!brk_pend) begin
                if (held_match) begin
                  key_repeat <= 1'b1;
                end else begin
                  key_repeat  <= 1'b0;
                  press_count <= press_count + 8'd1;
                  held_code   <= fifo_data;
                  held_ext    <= ext_pend;
                  key_held    <= 1'b1;
                end
              end else begin
                key_repeat <= 1'b0;
                if (held_match) begin
                  key_held <= 1'b0;
                end
              end
            end
          end else if (ext_pend || brk_pend) begin
            if (timer_expired) begin
              ext_pend <= 1'b0;
              brk_pend <= 1'b0;
              timer    <= 24'd0;
            end else begin
              timer <= timer_inc;
            end
          end
        end
        POP: begin
          state           <= GAP;
          fifo_nextdata_n <= 1'b1;
        end
        GAP: begin
          state <= WAIT;
        end
        default: begin
          state           <= WAIT;
          fifo_nextdata_n <= 1'b1;
        end
      endcase
    end
  end

  // Each sticky flag gives its own set condition priority over the clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_err <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      if (fifo_overflow) begin
        overflow_err <= 1'b1;
      end else if (clr_err) begin
        overflow_err <= 1'b0;
      end
      if (timer_expired) begin
        timeout_err <= 1'b1;
      end else if (clr_err) begin
        timeout_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Self-checking bench for ps2_key_sequencer: scripted table, hand corner cases, and a
// randomized byte stream checked against a scan-code-level reference model.
module tb_ps2_key_sequencer;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       rel;
    logic       rep;
    logic       held;
    logic [7:0] cnt;
  } ev_t;

  typedef struct packed {
    logic [7:0] b;
    logic       valid;
    ev_t        ev;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [7:0] fifo_data;
  logic       fifo_ready;
  logic       fifo_overflow;
  logic       fifo_nextdata_n;
  logic       clr_err;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_release;
  logic       key_repeat;
  logic       key_held;
  logic [7:0] press_count;
  logic       overflow_err;
  logic       timeout_err;

  int n_cmp = 0;
  int n_fail = 0;
  int pulses = 0;

  logic [7:0] fifo_q[$];
  ev_t        act_q[$];
  ev_t        exp_q[$];

  logic       m_ext, m_brk, m_held, m_hext;
  logic [7:0] m_hcode, m_cnt;

  ps2_key_sequencer #(.PREFIX_TIMEOUT(24'd10)) dut (
    .clk             (clk),
    .rst             (rst),
    .fifo_data       (fifo_data),
    .fifo_ready      (fifo_ready),
    .fifo_overflow   (fifo_overflow),
    .fifo_nextdata_n (fifo_nextdata_n),
    .clr_err         (clr_err),
    .key_valid       (key_valid),
    .key_code        (key_code),
    .key_ext         (key_ext),
    .key_release     (key_release),
    .key_repeat      (key_repeat),
    .key_held        (key_held),
    .press_count     (press_count),
    .overflow_err    (overflow_err),
    .timeout_err     (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // FIFO model: head presented on the falling edge, popped on a rising edge with nextdata_n low.
  always @(negedge clk) begin
    fifo_ready = (fifo_q.size() != 0);
    fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  end

  always @(posedge clk) begin
    logic [7:0] tmp;
    if (rst && !fifo_nextdata_n && fifo_q.size() != 0) tmp = fifo_q.pop_front();
  end

  always @(negedge clk) begin
    if (rst) begin
      if (!fifo_nextdata_n) pulses++;
      if (key_valid) begin
        act_q.push_back({key_code, key_ext, key_release, key_repeat, key_held, press_count});
        check("valid_during_pop", {31'd0, fifo_nextdata_n}, 32'd0);
      end
    end
  end

  function automatic vec_t mk(input logic [7:0] b, input logic v, input logic [7:0] code,
                              input logic ext, input logic rel, input logic rep,
                              input logic held, input logic [7:0] cnt);
    vec_t r;
    r.b = b; r.valid = v;
    r.ev = '{code: code, ext: ext, rel: rel, rep: rep, held: held, cnt: cnt};
    return r;
  endfunction

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_held = 0; m_hext = 0; m_hcode = 8'h00; m_cnt = 8'h00;
  endtask

  // Reference: one key slot, prefixes accumulate until a non-prefix byte consumes them.
  task automatic model_byte(input logic [7:0] b);
    ev_t e;
    logic same;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      same = m_held && (m_hcode == b) && (m_hext == m_ext);
      e.code = b; e.ext = m_ext; e.rel = m_brk; e.rep = 0;
      if (!m_brk) begin
        if (same) e.rep = 1;
        else begin m_cnt = m_cnt + 8'd1; m_hcode = b; m_hext = m_ext; m_held = 1; end
      end else if (same) m_held = 0;
      e.held = m_held; e.cnt = m_cnt;
      exp_q.push_back(e);
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic push_m(input logic [7:0] b);
    fifo_q.push_back(b);
    model_byte(b);
  endtask

  task automatic drain();
    int i = 0;
    while (fifo_q.size() != 0 && i < 5000) begin @(negedge clk); i++; end
    if (i >= 5000) begin
      n_cmp++; n_fail++;
      $display("FAIL drain: fifo still holds %0d bytes, required 0", fifo_q.size());
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_pop();
    int i = 0;
    @(negedge clk);
    while (fifo_nextdata_n && i < 100) begin @(negedge clk); i++; end
    if (i >= 100) begin
      n_cmp++; n_fail++;
      $display("FAIL wait_pop: nextdata_n stayed 1, required a pop");
    end
  endtask

  task automatic compare_events(input string tag);
    check({tag, "_count"}, act_q.size(), exp_q.size());
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_ev%0d", tag, i), {12'd0, act_q[i]}, {12'd0, exp_q[i]});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 0;
    fifo_q.delete(); act_q.delete(); exp_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1;
  endtask

  function automatic ev_t live();
    return {key_code, key_ext, key_release, key_repeat, key_held, press_count};
  endfunction

  initial begin
    vec_t tbl[22];
    ev_t  last;
    int   ev0, p0;
    logic [7:0] rb;

    tbl[0]  = mk(8'h1C, 1, 8'h1C, 0, 0, 0, 1, 8'd1);
    tbl[1]  = mk(8'hF0, 0, 8'h00, 0, 0, 0, 0, 8'd0);
    tbl[2]  = mk(8'h1C, 1, 8'h1C, 0, 1, 0, 0, 8'd1);
    tbl[3]  = mk(8'hE0, 0, 8'h00, 0, 0, 0, 0, 8'd0);
    tbl[4]  = mk(8'hF0, 0, 8'h00, 0, 0, 0, 0, 8'd0);
    tbl[5]  = mk(8'h75, 1, 8'h75, 1, 1, 0, 0, 8'd1);
    tbl[6]  = mk(8'h1C, 1, 8'h1C, 0, 0, 0, 1, 8'd2);
    tbl[7]  = mk(8'h1C, 1, 8'h1C, 0, 0, 1, 1, 8'd2);
    tbl[8]  = mk(8'h1C, 1, 8'h1C, 0, 0, 1, 1, 8'd2);
    tbl[9]  = mk(8'hE0, 0, 8'h00, 0, 0, 0, 0, 8'd0);
    tbl[10] = mk(8'h1C, 1, 8'h1C, 1, 0, 0, 1, 8'd3);
    tbl[11] = mk(8'hF0, 0, 8'h00, 0, 0, 0, 0, 8'd0);
    tbl[12] = mk(8'h1C, 1, 8'h1C, 0, 1, 0, 1, 8'd3);
    tbl[13] = mk(8'hE0, 0, 8'h00, 0, 0, 0, 0, 8'd0);
    tbl[14] = mk(8'hF0, 0, 8'h00, 0, 0, 0, 0, 8'd0);
    tbl[15] = mk(8'h1C, 1, 8'h1C, 1, 1, 0, 0, 8'd3);
    tbl[16] = mk(8'hE0, 0, 8'h00, 0, 0, 0, 0, 8'd0);
    tbl[17] = mk(8'hE0, 0, 8'h00, 0, 0, 0, 0, 8'd0);
    tbl[18] = mk(8'h75, 1, 8'h75, 1, 0, 0, 1, 8'd4);
    tbl[19] = mk(8'hF0, 0, 8'h00, 0, 0, 0, 0, 8'd0);
    tbl[20] = mk(8'hF0, 0, 8'h00, 0, 0, 0, 0, 8'd0);
    tbl[21] = mk(8'h5A, 1, 8'h5A, 0, 1, 0, 1, 8'd4);

    rst = 0; fifo_overflow = 0; clr_err = 0; fifo_ready = 0; fifo_data = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_outputs", {12'd0, live()}, 32'd0);
    check("rst_nextdata_n", {31'd0, fifo_nextdata_n}, 32'd1);
    check("rst_flags", {29'd0, key_valid, overflow_err, timeout_err}, 32'd0);
    rst = 1;
    repeat (2) @(negedge clk);

    // Scripted table: one byte per row, event presence and held outputs checked after each.
    last = '0;
    for (int i = 0; i < 22; i++) begin
      ev0 = act_q.size(); p0 = pulses;
      fifo_q.push_back(tbl[i].b);
      drain();
      check($sformatf("row%0d_events", i), act_q.size() - ev0, {31'd0, tbl[i].valid});
      check($sformatf("row%0d_pops", i), pulses - p0, 32'd1);
      if (tbl[i].valid) begin
        last = tbl[i].ev;
        if (act_q.size() > ev0) check($sformatf("row%0d_event", i), {12'd0, act_q[ev0]}, {12'd0, last});
      end
      check($sformatf("row%0d_hold", i), {12'd0, live()}, {12'd0, last});
      check($sformatf("row%0d_valid_low", i), {31'd0, key_valid}, 32'd0);
    end

    // Timer restarts on each popped byte: two 8-cycle idle gaps never expire.
    fifo_q.push_back(8'hF0); wait_pop(); repeat (8) @(posedge clk); @(negedge clk);
    fifo_q.push_back(8'hF0); wait_pop(); repeat (8) @(posedge clk); @(negedge clk);
    ev0 = act_q.size();
    fifo_q.push_back(8'h33); drain();
    check("restart_timeout_err", {31'd0, timeout_err}, 32'd0);
    check("restart_release", {31'd0, key_release}, 32'd1);
    check("restart_events", act_q.size() - ev0, 32'd1);

    // Prefix expiry exactly at the 10th idle WAIT cycle.
    fifo_q.push_back(8'hF0); wait_pop();
    repeat (11) @(posedge clk); @(negedge clk);
    check("timeout_before", {31'd0, timeout_err}, 32'd0);
    @(posedge clk); @(negedge clk);
    check("timeout_at", {31'd0, timeout_err}, 32'd1);
    ev0 = act_q.size();
    fifo_q.push_back(8'h1C); drain();
    check("timeout_events", act_q.size() - ev0, 32'd1);
    check("timeout_make", {23'd0, key_code, key_release}, {23'd0, 8'h1C, 1'b0});

    // Overflow set beats clear; the idle timeout flag clears in the same cycle.
    @(negedge clk); fifo_overflow = 1; clr_err = 1;
    @(negedge clk); fifo_overflow = 0; clr_err = 0;
    check("ovf_priority", {31'd0, overflow_err}, 32'd1);
    check("clr_timeout", {31'd0, timeout_err}, 32'd0);
    @(negedge clk); clr_err = 1;
    @(negedge clk); clr_err = 0;
    check("clr_overflow", {31'd0, overflow_err}, 32'd0);

    // press_count wrap with 256 alternating makes from a fresh reset.
    do_reset();
    for (int i = 0; i < 255; i++) push_m((i % 2 == 1) ? 8'h22 : 8'h21);
    drain();
    check("wrap_ff", {24'd0, press_count}, 32'hFF);
    push_m(8'h22);
    drain();
    check("wrap_00", {24'd0, press_count}, 32'h00);
    compare_events("wrap");

    // Randomized byte stream with random inter-byte gaps.
    act_q.delete(); exp_q.delete();
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    rb = 8'hE0;
        2, 3:    rb = 8'hF0;
        4, 5:    rb = 8'h1C;
        6:       rb = 8'h1B;
        7:       rb = 8'h75;
        8:       rb = 8'h5A;
        default: rb = 8'($urandom_range(1, 127));
      endcase
      push_m(rb);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    push_m(8'h1B);
    drain();
    compare_events("rand");

    // Reset in the middle of an E0 pop abandons the pop and the prefix.
    @(negedge clk); fifo_overflow = 1;
    @(negedge clk); fifo_overflow = 0;
    fifo_q.push_back(8'hE0);
    wait_pop();
    #1 rst = 0;
    #1;
    check("midpop_nextdata_n", {31'd0, fifo_nextdata_n}, 32'd1);
    check("midpop_outputs", {12'd0, live()}, 32'd0);
    check("midpop_flags", {29'd0, key_valid, overflow_err, timeout_err}, 32'd0);
    fifo_q.delete(); act_q.delete(); exp_q.delete(); model_reset();
    repeat (2) @(negedge clk);
    rst = 1;
    push_m(8'h1C);
    drain();
    compare_events("post_reset");
    check("post_reset_ext", {31'd0, key_ext}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ps2_key_sequencer.md
PS2_KEY_SEQUENCER -- requirements
Module: ps2_key_sequencer

Interface
REQ-001 SHALL have parameter: PREFIX_TIMEOUT, default 24'd1000000, the number of clk cycles a pending E0/F0 prefix may wait for its next byte.
REQ-002 SHALL have port: clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port: fifo_data  input  8  scan-code byte at the head of the keyboard receiver FIFO.
REQ-005 SHALL have port: fifo_ready  input  1  high while the FIFO is non-empty.
REQ-006 SHALL have port: fifo_overflow  input  1  receiver FIFO overflow indication.
REQ-007 SHALL have port: fifo_nextdata_n  output  1  active-low pop strobe to the FIFO.
REQ-008 SHALL have port: clr_err  input  1  synchronous clear for the sticky error flags.
REQ-009 SHALL have port: key_valid  output  1  one-cycle key-event strobe.
REQ-010 SHALL have port: key_code  output  8  scan code of the last event, excluding prefixes.
REQ-011 SHALL have port: key_ext  output  1  the last event was E0-prefixed.
REQ-012 SHALL have port: key_release  output  1  the last event was F0-prefixed (break).
REQ-013 SHALL have port: key_repeat  output  1  the last event was a typematic repeat of the held key.
REQ-014 SHALL have port: key_held  output  1  a key is currently held.
REQ-015 SHALL have port: press_count  output  8  count of new key presses.
REQ-016 SHALL have port: overflow_err  output  1  sticky; set by fifo_overflow.
REQ-017 SHALL have port: timeout_err  output  1  sticky; set when a prefix expires.

Function
REQ-018 SHALL implement FSM states WAIT, POP, GAP; WAIT->POP when fifo_ready=1; POP->GAP unconditionally; GAP->WAIT unconditionally.
REQ-019 SHALL latch fifo_data on the WAIT->POP edge.
REQ-020 SHALL drive fifo_nextdata_n (registered) low only in POP, i.e. exactly one cycle per byte; high in all other states.
REQ-021 SHALL NOT sample fifo_ready in POP or GAP; the minimum period per byte is 3 cycles.
REQ-022 SHALL classify the byte in POP as follows:
- 8'hE0: set ext_pend; no event.
- 8'hF0: set brk_pend; no event.
- Any other value: emit an event.
REQ-023 SHALL, on an event, assert key_valid during POP (the cycle after ready was sampled) with key_code=byte, key_ext=ext_pend, key_release=brk_pend; ext_pend and brk_pend are then cleared.
REQ-024 SHALL hold key_code/key_ext/key_release/key_repeat until the next event.
REQ-025 SHALL track one held key (held_code, held_ext). A make event is handled as follows:
- Make matching a held key: key_repeat=1, press_count unchanged.
- Any other make: key_repeat=0, press_count+1 (wrapping 8'hFF->8'h00), held_code/held_ext updated, key_held=1.
REQ-026 SHALL handle a break event as follows:
- Break matching held_code and held_ext: key_held=0, key_repeat=0.
- Break not matching: the event is still emitted, and held state is unchanged.
REQ-027 SHALL keep ext_pend set across a following F0 (E0 F0 xx yields key_ext=1, key_release=1); a repeated E0 or F0 is idempotent.
REQ-028 SHALL run a prefix timer while ext_pend|brk_pend=1 and the FSM is in WAIT:
- Reaching PREFIX_TIMEOUT clears both pend flags and sets timeout_err; no event is emitted.
- The timer restarts on every popped byte.
REQ-029 SHALL set overflow_err on any cycle fifo_overflow=1. Set has priority over clr_err in the same cycle.
REQ-030 SHALL clear both sticky errors on clr_err=1 unless a set condition is present that cycle.

Reset
REQ-031 SHALL, while rst=0, asynchronously force:
- FSM to WAIT and fifo_nextdata_n=1.
- key_valid, key_ext, key_release, key_repeat, key_held = 0.
- key_code=8'h00, press_count=8'h00.
- Both sticky errors = 0, pend flags = 0, timer = 0.
REQ-032 SHALL, on reset assertion mid-POP, abandon the pop (nextdata_n returns high immediately) and discard any partial prefix.

Verification
REQ-033 SHALL cover single make/break: FIFO 1C, F0, 1C -> two key_valid pulses (1C make, press_count=1, key_held=1; then 1C release, key_held=0); exactly three nextdata_n pulses.
REQ-034 SHALL cover extended key: E0, F0, 75 -> one event with key_code=75, key_ext=1, key_release=1; no event for the prefixes.
REQ-035 SHALL cover typematic repeat: 1C,1C,1C -> three events with key_repeat=0,1,1 and press_count=1.
REQ-036 SHALL cover count wrap: 256 distinct alternating makes (press_count preset to 8'hFF) -> press_count wraps to 8'h00.
REQ-037 SHALL cover timeout with PREFIX_TIMEOUT=10: F0, then idle for 10 cycles -> timeout_err=1; a following 1C is a make (key_release=0).
REQ-038 SHALL cover error priority and reset: fifo_overflow=1 and clr_err=1 in the same cycle -> overflow_err=1; rst=0 during POP -> fifo_nextdata_n=1 in the same cycle, and all outputs reach their reset values.
